julia_calc: RTL and testbench
=============================

JULIA_CALC -- requirements
Module: julia_calc

Interface
REQ-001 Parameter FRAC_BITS, default 13, SHALL set the fixed-point fraction width: value = integer / 8192.
REQ-002 Parameter MAX_ITER, default 255, SHALL set the maximum iteration count.
REQ-003 Port CLK, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port RST, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port ZR, input, 32-bit signed: real part of the initial z, Q18.13.
REQ-006 Port ZI, input, 32-bit signed: imaginary part of the initial z, Q18.13.
REQ-007 Port CR, input, 32-bit signed: real part of the constant c, Q18.13.
REQ-008 Port CI, input, 32-bit signed: imaginary part of the constant c, Q18.13.
REQ-009 Port CALC_START, input, 1 bit: level request, held high by the requester until CALC_END is seen.
REQ-010 Port CALC_NUM, output, 32-bit signed: escape iteration count (0..MAX_ITER), registered.
REQ-011 Port CALC_END, output, 1 bit: result-valid flag, registered.

Function
REQ-012 The block SHALL implement the FSM states IDLE, CALC and DONE.
REQ-013 IDLE: when CALC_START is sampled high, the block SHALL latch ZR, ZI, CR and CI into internal zr, zi, cr and ci, clear the count and go to CALC; CALC_END SHALL be 0 in IDLE.
REQ-014 CALC, one iteration per clock, SHALL compute:
- sq_r = (zr*zr) >>> 13
- sq_i = (zi*zi) >>> 13
- cross = (zr*zi) >>> 12 (that is, 2*zr*zi)
- Products SHALL be full 64-bit signed and the shifts arithmetic.
REQ-015 Escape test: if sq_r + sq_i > 4*2^13 (= 32768), the block SHALL go to DONE with CALC_NUM = count.
- The sum SHALL be evaluated at 64-bit width; no wrap is allowed.
- Equality (|z|^2 = 4.0) SHALL NOT escape.
REQ-016 Otherwise, if count == MAX_ITER, the block SHALL go to DONE with CALC_NUM = MAX_ITER.
REQ-017 Otherwise the block SHALL update zr <= sq_r - sq_i + cr and zi <= cross + ci, truncated to 32 bits, and set count <= count + 1.
REQ-018 DONE: CALC_END SHALL be 1 and CALC_NUM SHALL be held stable; when CALC_START is sampled low the block SHALL return to IDLE and clear CALC_END on that edge.
REQ-019 Latency: with CALC_START sampled high at edge t and escape at count k, CALC_END SHALL rise at edge t+2+k.
REQ-020 CALC_NUM SHALL keep its last value in IDLE until the next result is written.
REQ-021 CALC_START deasserted during CALC SHALL NOT abort the computation; the block SHALL enter DONE, show CALC_END for one cycle, then return to IDLE.
REQ-022 Input changes after the latch edge SHALL NOT affect a running computation.
REQ-023 After DONE -> IDLE, a CALC_START still or again high SHALL start a new computation on the next edge.

Reset
REQ-024 RST low SHALL asynchronously force state IDLE, CALC_END = 0, CALC_NUM = 0, and clear zr, zi, cr, ci and count, including mid-CALC or in DONE.
REQ-025 On RST release the block SHALL wait in IDLE for CALC_START.

Verification
REQ-026 Z = (0,0), C = (0,0), CALC_START held -> CALC_END after 257 cycles, CALC_NUM = 255.
REQ-027 Z = (24576,0) (3.0), any C -> CALC_NUM = 0, CALC_END at edge t+2.
REQ-028 Z = (16384,0) (2.0), C = (0,0) -> no escape at exactly 4.0, CALC_NUM = 1.
REQ-029 Z = (0,0), C = (8192,0) (1.0) -> iterates z = 1, 2, 5, CALC_NUM = 3; CALC_END stays 1 until CALC_START drops, then 0 one edge later.
REQ-030 RST pulsed low mid-CALC -> CALC_END = 0 and CALC_NUM = 0 immediately; a new request afterwards computes correctly.
REQ-031 Raster sweep: ZR, ZI over [-2,2), C = (-328,-5693), with back-to-back requests -> each result matches a bit-accurate reference model.

Source files
------------

// File: rtl/julia_calc.sv
// julia_calc: iterative Julia-set escape-time engine, Q18.13 fixed point.
// One z <- z^2 + c iteration per clock; reports the escape count or MAX_ITER.
module julia_calc #(
  parameter int FRAC_BITS = 13,
  parameter int MAX_ITER  = 255
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic signed [31:0] ZR,
  input  logic signed [31:0] ZI,
  input  logic signed [31:0] CR,
  input  logic signed [31:0] CI,
  input  logic               CALC_START,
  output logic signed [31:0] CALC_NUM,
  output logic               CALC_END
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // |z|^2 threshold of 4.0 in the squared-value scale
  localparam logic signed [63:0] ESC_LIM = 64'sd4 <<< FRAC_BITS;

  state_t             r_state;
  logic signed [31:0] r_zr, r_zi, r_cr, r_ci;
  logic signed [31:0] r_num;
  logic        [31:0] r_count;
  logic               r_end;

  logic signed [63:0] w_zr64, w_zi64;
  logic signed [63:0] w_prr, w_pii, w_pri;
  logic signed [63:0] w_sq_r, w_sq_i, w_cross, w_mag;
  logic signed [31:0] w_zr_nxt, w_zi_nxt;
  logic               w_esc;
  logic               w_unused;

  // Full-width signed products so the escape test can never wrap
  assign w_zr64  = {{32{r_zr[31]}}, r_zr};
  assign w_zi64  = {{32{r_zi[31]}}, r_zi};
  assign w_prr   = w_zr64 * w_zr64;
  assign w_pii   = w_zi64 * w_zi64;
  assign w_pri   = w_zr64 * w_zi64;
  assign w_sq_r  = w_prr >>> FRAC_BITS;
  assign w_sq_i  = w_pii >>> FRAC_BITS;
  // One bit less of shift doubles the cross term (2*zr*zi)
  assign w_cross = w_pri >>> (FRAC_BITS - 1);
  assign w_mag   = w_sq_r + w_sq_i;
  // Strictly greater: |z|^2 == 4.0 keeps iterating
  assign w_esc   = w_mag > ESC_LIM;

  // Next z is truncated to 32 bits, so only the low words matter
  assign w_zr_nxt = w_sq_r[31:0] - w_sq_i[31:0] + r_cr;
  assign w_zi_nxt = w_cross[31:0] + r_ci;
  assign w_unused = ^w_cross[63:32];

  assign CALC_NUM = r_num;
  assign CALC_END = r_end;

  // Control FSM: latch operands, iterate, then hold the result for the requester.
  // DONE raises CALC_END one edge after entry and only releases once CALC_END
  // has been visible, so an early-dropped request still sees a one-cycle pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_zr    <= '0;
      r_zi    <= '0;
      r_cr    <= '0;
      r_ci    <= '0;
      r_count <= '0;
      r_num   <= '0;
      r_end   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_end <= 1'b0;
          if (CALC_START) begin
            r_zr    <= ZR;
            r_zi    <= ZI;
            r_cr    <= CR;
            r_ci    <= CI;
            r_count <= '0;
            r_state <= CALC;
          end
        end
        CALC: begin
          if (w_esc) begin
            r_num   <= r_count;
            r_state <= DONE;
          end else if (r_count == 32'(MAX_ITER)) begin
            r_num   <= 32'(MAX_ITER);
            r_state <= DONE;
          end else begin
            r_zr    <= w_zr_nxt;
            r_zi    <= w_zi_nxt;
            r_count <= r_count + 32'd1;
          end
        end
        DONE: begin
          if (!r_end) begin
            r_end <= 1'b1;
          end else if (!CALC_START) begin
            r_end   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_julia_calc.sv
// tb_julia_calc: directed and randomized checks of julia_calc against an
// arithmetic escape-time model.
module tb_julia_calc;

  localparam int FRAC_BITS = 13;
  localparam int MAX_ITER  = 255;

  logic               CLK;
  logic               RST;
  logic signed [31:0] ZR, ZI, CR, CI;
  logic               CALC_START;
  logic signed [31:0] CALC_NUM;
  logic               CALC_END;

  int checks   = 0;
  int failures = 0;

  julia_calc #(.FRAC_BITS(FRAC_BITS), .MAX_ITER(MAX_ITER)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ZR         (ZR),
    .ZI         (ZI),
    .CR         (CR),
    .CI         (CI),
    .CALC_START (CALC_START),
    .CALC_NUM   (CALC_NUM),
    .CALC_END   (CALC_END)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Escape-time model: iterate z^2 + c in fixed point until |z|^2 > 4.0
  function automatic int ref_iter(int zr0, int zi0, int cr, int ci);
    longint lim = 64'sd4 <<< FRAC_BITS;
    int zr = zr0;
    int zi = zi0;
    for (int k = 0; k <= MAX_ITER; k++) begin
      longint a  = longint'(zr);
      longint b  = longint'(zi);
      longint rr = (a * a) >>> FRAC_BITS;
      longint ii = (b * b) >>> FRAC_BITS;
      longint ri = (a * b) >>> (FRAC_BITS - 1);
      if (rr + ii > lim) return k;
      if (k == MAX_ITER) return k;
      zr = int'(rr - ii + longint'(cr));
      zi = int'(ri + longint'(ci));
    end
    return MAX_ITER;
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one request from just after an edge; scramble inputs after the
  // latch edge; measure latency from the latch edge to CALC_END.
  task automatic run_calc(input string tag, input int zr, input int zi,
                          input int cr, input int ci, input int exp_num,
                          input bit drop_early);
    int cyc;
    ZR = zr; ZI = zi; CR = cr; CI = ci;
    CALC_START = 1'b1;
    @(posedge CLK); #1;
    ZR = $urandom; ZI = $urandom; CR = $urandom; CI = $urandom;
    if (drop_early) CALC_START = 1'b0;
    cyc = 0;
    while (CALC_END !== 1'b1 && cyc < 600) begin
      @(posedge CLK); #1;
      cyc++;
    end
    check({tag, "_num"}, CALC_NUM, exp_num);
    check({tag, "_lat"}, cyc, exp_num + 2);
    if (drop_early) begin
      @(posedge CLK); #1;
      check({tag, "_pulse"}, CALC_END, 1'b0);
    end else begin
      @(posedge CLK); #1;
      check({tag, "_hold_end"}, CALC_END, 1'b1);
      check({tag, "_hold_num"}, CALC_NUM, exp_num);
      CALC_START = 1'b0;
      @(posedge CLK); #1;
      check({tag, "_clr_end"}, CALC_END, 1'b0);
      check({tag, "_keep_num"}, CALC_NUM, exp_num);
    end
  endtask

  initial begin
    int zr, zi, cr, ci;
    RST = 1'b0;
    CALC_START = 1'b0;
    ZR = '0; ZI = '0; CR = '0; CI = '0;
    #3;
    check("rst_end", CALC_END, 1'b0);
    check("rst_num", CALC_NUM, 0);
    #20 RST = 1'b1;
    @(posedge CLK); #1;
    check("idle_end", CALC_END, 1'b0);

    // z=0, c=1.0: z = 1, 2, 5 -> escapes at count 3
    run_calc("c1", 0, 0, 8192, 0, 3, 1'b0);
    // z=3.0 escapes immediately regardless of c
    run_calc("z3", 24576, 0, int'($urandom), int'($urandom), 0, 1'b0);
    // |z|^2 exactly 4.0 must not escape
    run_calc("z2", 16384, 0, 0, 0, 1, 1'b0);
    // origin never escapes -> MAX_ITER after 257 cycles
    run_calc("zero", 0, 0, 0, 0, MAX_ITER, 1'b0);
    // request dropped during CALC still completes with a one-cycle pulse
    run_calc("early", 0, 0, 8192, 0, 3, 1'b1);

    // asynchronous reset in the middle of a long computation
    ZR = 0; ZI = 0; CR = 0; CI = 0;
    CALC_START = 1'b1;
    repeat (50) @(posedge CLK);
    #3 RST = 1'b0;
    #1;
    check("midrst_end", CALC_END, 1'b0);
    check("midrst_num", CALC_NUM, 0);
    CALC_START = 1'b0;
    @(posedge CLK);
    #2 RST = 1'b1;
    @(posedge CLK); #1;
    check("postrst_end", CALC_END, 1'b0);
    run_calc("postrst", 8192, 0, 0, 0, ref_iter(8192, 0, 0, 0), 1'b0);

    // raster sweep over [-2,2) x [-2,2), back-to-back requests
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        zr = -16384 + x * 4096;
        zi = -16384 + y * 4096;
        run_calc("raster", zr, zi, -328, -5693, ref_iter(zr, zi, -328, -5693), 1'b1);
      end
    end

    // random z in [-2,2) and c in [-1,1)
    for (int n = 0; n < 24; n++) begin
      zr = int'($urandom_range(0, 32767)) - 16384;
      zi = int'($urandom_range(0, 32767)) - 16384;
      cr = int'($urandom_range(0, 16383)) - 8192;
      ci = int'($urandom_range(0, 16383)) - 8192;
      run_calc("rand", zr, zi, cr, ci, ref_iter(zr, zi, cr, ci), n[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
